spike_count_classifier: RTL and testbench
=========================================

SPIKE_COUNT_CLASSIFIER -- requirements
Module: spike_count_classifier

Interface
REQ-001 The block SHALL have parameter NUM_NEURONS, default 1: width of the spike vector produced by the IF layer.
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 16: width of each per-neuron spike counter.
REQ-003 The block SHALL have parameter WINDOW_WIDTH, default 16: width of the window length.
REQ-004 The block SHALL have localparam IDX_WIDTH = max(1, $clog2(NUM_NEURONS)).
REQ-005 The block SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port spike_in, input, NUM_NEURONS bits: output spike vector of the IF layer, one bit per neuron.
REQ-008 The block SHALL have port start, input, 1 bit: request to begin a classification window.
REQ-009 The block SHALL have port window_len, input, WINDOW_WIDTH bits: number of timesteps to count, sampled with start.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 The block SHALL have port result_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port result_ready, input, 1 bit: consumer accepts the result.
REQ-013 The block SHALL have port result_idx, output, IDX_WIDTH bits: index of the winning neuron.
REQ-014 The block SHALL have port result_count, output, COUNT_WIDTH bits: spike count of the winning neuron.

Function
REQ-015 The FSM SHALL have states IDLE, COUNT, ARGMAX and DONE.
REQ-016 In IDLE, start high at an edge SHALL latch window_len, zero all counters, and move to COUNT; start is ignored in every other state.
REQ-017 A latched window_len of 0 SHALL skip COUNT and go directly to ARGMAX, with all counts 0.
REQ-018 In COUNT, each edge SHALL add spike_in[i] to counter i and decrement the remaining-window counter; after exactly window_len sampled edges the FSM SHALL move to ARGMAX.
REQ-019 ARGMAX SHALL scan one neuron per cycle, index 0 to NUM_NEURONS-1, taking exactly NUM_NEURONS cycles, then move to DONE.
REQ-020 The winner SHALL be the neuron with the strictly largest count; on a tie the lowest index wins; with all counts 0 the result is idx 0, count 0.
REQ-021 For a start accepted at edge E with length W, result_valid SHALL first be high after edge E+W+NUM_NEURONS.
REQ-022 In DONE, result_valid SHALL stay high, and result_idx and result_count SHALL stay stable, until result_ready is high at an edge; the FSM then returns to IDLE.
REQ-023 If start and result_ready are both high in DONE, only the result_ready handshake SHALL take effect; start is not accepted until IDLE.
REQ-024 result_idx and result_count SHALL hold the last result while in IDLE.

Reset
REQ-025 rst high at an edge SHALL force IDLE in every state, including mid-COUNT or mid-ARGMAX, and abandon any window in progress.
REQ-026 On reset, busy=0, result_valid=0, result_idx=0, result_count=0, all counters=0 and the remaining-window counter=0.
REQ-027 rst SHALL take priority over start and result_ready in the same cycle.

Configuration
REQ-028 With macro SCC_SATURATE_EN defined, each counter SHALL saturate at 2^COUNT_WIDTH-1 and further spikes leave it unchanged.
REQ-029 Without SCC_SATURATE_EN, each counter SHALL wrap modulo 2^COUNT_WIDTH.
REQ-030 No other behaviour SHALL depend on SCC_SATURATE_EN.

Verification
REQ-031 Scenario: NUM_NEURONS=4, window_len=10, neuron 2 spikes every cycle, others never -> result_idx=2, result_count=10, result_valid rises after edge E+14.
REQ-032 Scenario: tie, neurons 1 and 3 each spike 5 times in window 8 -> result_idx=1, result_count=5.
REQ-033 Scenario: window_len=0 -> result_idx=0, result_count=0, result_valid after edge E+NUM_NEURONS.
REQ-034 Scenario: COUNT_WIDTH=3, neuron 0 spikes 10 times -> count 7 with SCC_SATURATE_EN, count 2 without.
REQ-035 Scenario: hold result_ready low for 5 cycles in DONE -> result_valid, result_idx and result_count stay stable; start pulses in DONE are ignored; result_ready high -> IDLE next cycle.
REQ-036 Scenario: rst pulsed mid-COUNT -> all outputs at reset values next cycle; a new start then yields a correct fresh result with no carry-over of counts.

Source files
------------

// File: rtl/spike_count_classifier.sv
// Spike-count classifier: counts IF-layer spikes over a window, then scans for the argmax neuron.
// Optional SCC_SATURATE_EN makes the per-neuron counters saturate instead of wrapping.
module spike_count_classifier #(
    parameter  int NUM_NEURONS  = 1,
    parameter  int COUNT_WIDTH  = 16,
    parameter  int WINDOW_WIDTH = 16,
    localparam int IDX_WIDTH    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_NEURONS-1:0]  spike_in,
    input  logic                    start,
    input  logic [WINDOW_WIDTH-1:0] window_len,
    output logic                    busy,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [IDX_WIDTH-1:0]    result_idx,
    output logic [COUNT_WIDTH-1:0]  result_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_ARGMAX = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]              r_state;
    logic [WINDOW_WIDTH-1:0] r_remain;
    logic [IDX_WIDTH-1:0]    r_scan;
    logic [IDX_WIDTH-1:0]    r_best_idx;
    logic [COUNT_WIDTH-1:0]  r_best_cnt;
    logic [IDX_WIDTH-1:0]    r_result_idx;
    logic [COUNT_WIDTH-1:0]  r_result_cnt;
    logic [COUNT_WIDTH-1:0]  r_cnt     [NUM_NEURONS];
    logic [COUNT_WIDTH-1:0]  w_cnt_inc [NUM_NEURONS];

    logic [COUNT_WIDTH-1:0]  w_sel_cnt;
    logic                    w_take;
    logic [COUNT_WIDTH-1:0]  w_next_cnt;
    logic [IDX_WIDTH-1:0]    w_next_idx;
    logic                    w_scan_last;

    always_comb begin
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
`ifdef SCC_SATURATE_EN
            w_cnt_inc[i] = (spike_in[i] && (r_cnt[i] != '1)) ? r_cnt[i] + COUNT_WIDTH'(1) : r_cnt[i];
`else
            w_cnt_inc[i] = r_cnt[i] + COUNT_WIDTH'(spike_in[i]);
`endif
        end
    end

    // Compare-mux keeps the scan index free of array-bound width concerns for any NUM_NEURONS.
    always_comb begin
        w_sel_cnt = '0;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            if (r_scan == IDX_WIDTH'(i)) begin
                w_sel_cnt = r_cnt[i];
            end
        end
        w_take      = (w_sel_cnt > r_best_cnt);
        w_next_cnt  = w_take ? w_sel_cnt : r_best_cnt;
        w_next_idx  = w_take ? r_scan : r_best_idx;
        w_scan_last = (r_scan == IDX_WIDTH'(NUM_NEURONS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_remain     <= '0;
            r_scan       <= '0;
            r_best_idx   <= '0;
            r_best_cnt   <= '0;
            r_result_idx <= '0;
            r_result_cnt <= '0;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remain   <= window_len;
                        r_scan     <= '0;
                        r_best_idx <= '0;
                        r_best_cnt <= '0;
                        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                            r_cnt[i] <= '0;
                        end
                        r_state <= (window_len == '0) ? S_ARGMAX : S_COUNT;
                    end
                end
                S_COUNT: begin
                    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                        r_cnt[i] <= w_cnt_inc[i];
                    end
                    r_remain <= r_remain - WINDOW_WIDTH'(1);
                    if (r_remain == WINDOW_WIDTH'(1)) begin
                        r_state <= S_ARGMAX;
                    end
                end
                S_ARGMAX: begin
                    // Best starts at count 0, so strict '>' yields lowest-index-wins and idx 0 for all-zero.
                    r_best_cnt <= w_next_cnt;
                    r_best_idx <= w_next_idx;
                    r_scan     <= r_scan + IDX_WIDTH'(1);
                    if (w_scan_last) begin
                        r_result_idx <= w_next_idx;
                        r_result_cnt <= w_next_cnt;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign result_valid = (r_state == S_DONE);
    assign result_idx   = r_result_idx;
    assign result_count = r_result_cnt;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Directed self-checking bench for spike_count_classifier (4 neurons; a 3-bit-counter copy covers wrap/saturate).
module tb_spike_count_classifier;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  spike_in;
    logic        start;
    logic [15:0] window_len;
    logic        result_ready;

    logic        busy;
    logic        result_valid;
    logic [1:0]  result_idx;
    logic [15:0] result_count;

    logic        s_busy;
    logic        s_valid;
    logic [1:0]  s_idx;
    logic [2:0]  s_count;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    always #5 clk = ~clk;

    spike_count_classifier #(
        .NUM_NEURONS (4),
        .COUNT_WIDTH (16),
        .WINDOW_WIDTH(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spike_in    (spike_in),
        .start       (start),
        .window_len  (window_len),
        .busy        (busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_idx  (result_idx),
        .result_count(result_count)
    );

    spike_count_classifier #(
        .NUM_NEURONS (4),
        .COUNT_WIDTH (3),
        .WINDOW_WIDTH(16)
    ) dut_small (
        .clk         (clk),
        .rst         (rst),
        .spike_in    (spike_in),
        .start       (start),
        .window_len  (window_len),
        .busy        (s_busy),
        .result_valid(s_valid),
        .result_ready(result_ready),
        .result_idx  (s_idx),
        .result_count(s_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window(input int w);
        window_len = 16'(w);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Drives pat_a for the first na count edges then pat_b; returns edges from start to result_valid.
    task automatic run_until_valid(input logic [3:0] pat_a, input int na, input logic [3:0] pat_b,
                                   output int edges);
        edges = 0;
        while (!result_valid && edges < 200) begin
            spike_in = (edges < na) ? pat_a : pat_b;
            tick();
            edges++;
        end
        spike_in = '0;
    endtask

    task automatic ack();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("ack_busy", busy, 0);
        check("ack_valid", result_valid, 0);
    endtask

    initial begin
        rst          = 1'b1;
        spike_in     = '0;
        start        = 1'b0;
        window_len   = '0;
        result_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_idx", result_idx, 0);
        check("rst_count", result_count, 0);

        // reset wins over start
        start      = 1'b1;
        window_len = 16'd5;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio_busy", busy, 0);
        tick();
        check("rst_prio_busy2", busy, 0);

        // single active neuron, window 10
        start_window(10);
        check("s1_busy", busy, 1);
        run_until_valid(4'b0100, 100, 4'b0100, lat);
        check("s1_latency", lat, 14);
        check("s1_idx", result_idx, 2);
        check("s1_count", result_count, 10);

        // DONE holds for 5 cycles; start pulses ignored
        for (int j = 0; j < 5; j++) begin
            start = (j == 1 || j == 3);
            tick();
            start = 1'b0;
            check("hold_valid", result_valid, 1);
            check("hold_idx", result_idx, 2);
            check("hold_count", result_count, 10);
        end
        result_ready = 1'b1;
        start        = 1'b1;
        tick();
        result_ready = 1'b0;
        start        = 1'b0;
        check("both_busy", busy, 0);
        check("both_valid", result_valid, 0);
        check("idle_hold_idx", result_idx, 2);
        check("idle_hold_count", result_count, 10);
        tick();
        check("both_busy2", busy, 0);

        // tie between neurons 1 and 3
        start_window(8);
        run_until_valid(4'b1010, 5, 4'b0000, lat);
        check("tie_latency", lat, 12);
        check("tie_idx", result_idx, 1);
        check("tie_count", result_count, 5);
        ack();

        // zero-length window after nonzero counts
        start_window(0);
        run_until_valid(4'b1111, 100, 4'b1111, lat);
        check("w0_latency", lat, 4);
        check("w0_idx", result_idx, 0);
        check("w0_count", result_count, 0);
        ack();

        // neuron 0 spikes 10 times, neuron 1 spikes 3 times
        start_window(10);
        run_until_valid(4'b0011, 3, 4'b0001, lat);
        check("ovf_latency", lat, 14);
        check("ovf_idx_wide", result_idx, 0);
        check("ovf_count_wide", result_count, 10);
        check("ovf_small_valid", s_valid, 1);
`ifdef SCC_SATURATE_EN
        check("ovf_idx_small", s_idx, 0);
        check("ovf_count_small", s_count, 7);
`else
        check("ovf_idx_small", s_idx, 1);
        check("ovf_count_small", s_count, 3);
`endif
        ack();

        // reset mid-COUNT, then a fresh window
        start_window(10);
        spike_in = 4'b1000;
        for (int j = 0; j < 4; j++) tick();
        rst      = 1'b1;
        spike_in = '0;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_valid", result_valid, 0);
        check("midrst_idx", result_idx, 0);
        check("midrst_count", result_count, 0);
        tick();
        check("midrst_busy2", busy, 0);
        start_window(3);
        run_until_valid(4'b1010, 1, 4'b0010, lat);
        check("fresh_latency", lat, 7);
        check("fresh_idx", result_idx, 1);
        check("fresh_count", result_count, 3);
        ack();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
